program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length-prefixed, XOR-checksummed image
// and writes it word by word into instruction memory while holding the core in reset.
module program_loader #(
  parameter int MAX_WORDS = 128,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [6:0]  imem_address,
  output logic [31:0] imem_data,
  output logic        imem_wren,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]   MAX_LEN  = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERROR
  } state_t;

  state_t        state, state_next;
  logic [7:0]    len_lo;
  logic [15:0]   word_total;
  logic [15:0]   word_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_buf;
  logic [7:0]    checksum;
  logic [TW-1:0] tmo_cnt;
  logic [6:0]    address;

  logic        xfer;
  logic [15:0] len_rx;
  logic        len_ok;
  logic        tmo_hit;
  logic        last_word;

  assign rx_ready   = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CHECK);
  assign imem_wren  = (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);
  assign busy       = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign core_reset = !((state == ST_IDLE) || (state == ST_DONE));
  assign imem_address = address;
  assign imem_data    = word_buf;

  assign xfer      = rx_valid && rx_ready;
  assign len_rx    = {rx_data, len_lo};
  assign len_ok    = (len_rx != 16'd0) && ({1'b0, len_rx} <= MAX_LEN);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign last_word = (word_cnt == word_total - 16'd1);

  // A transfer in the same cycle as the timeout limit wins over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ERROR: if (start) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer)         state_next = ST_LEN_HI;
        else if (tmo_hit) state_next = ST_ERROR;
      end
      ST_LEN_HI: begin
        if (xfer)         state_next = len_ok ? ST_DATA : ST_ERROR;
        else if (tmo_hit) state_next = ST_ERROR;
      end
      ST_DATA: begin
        if (xfer) begin
          if (byte_cnt == 2'd3) state_next = ST_WRITE;
        end else if (tmo_hit) begin
          state_next = ST_ERROR;
        end
      end
      ST_WRITE: state_next = last_word ? ST_CHECK : ST_DATA;
      ST_CHECK: begin
        if (xfer)         state_next = (checksum == rx_data) ? ST_DONE : ST_ERROR;
        else if (tmo_hit) state_next = ST_ERROR;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      checksum   <= '0;
      tmo_cnt    <= '0;
      address    <= '0;
    end else begin
      state <= state_next;

      if ((state_next != state) || xfer)
        tmo_cnt <= '0;
      else if (rx_ready)
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            len_lo     <= '0;
            word_total <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            checksum   <= '0;
            address    <= '0;
          end
        end
        ST_LEN_LO: if (xfer) len_lo <= rx_data;
        ST_LEN_HI: if (xfer) word_total <= len_rx;
        ST_DATA: begin
          if (xfer) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            checksum <= checksum ^ rx_data;
          end
        end
        ST_WRITE: begin
          word_cnt <= word_cnt + 16'd1;
          // The address stops on the final word so it never steps past the memory.
          if (!last_word) address <= address + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
